// File: rtl/btb_ctrl.sv
// BTB sequencer: clears every entry after reset or flush, then turns EX resolutions into BTB writes and redirects.
// Sweep and update writes are registered (one cycle after EX); redirect is combinational; fetch stalls during a sweep.
module btb_ctrl #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 20,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_flush_req,
  input  logic               i_ex_valid,
  input  logic               i_ex_taken,
  input  logic               i_ex_btb_hit,
  input  logic               i_ex_target_match,
  input  logic [31:0]        i_ex_pc,
  input  logic [31:0]        i_ex_target,
  input  logic [31:0]        i_ex_pc_plus4,
  output logic               o_btb_wren,
  output logic [INDEX_W-1:0] o_btb_waddr,
  output logic [31:0]        o_btb_wtarget,
  output logic [TAG_W:0]     o_btb_wvt,
  output logic               o_redirect,
  output logic [31:0]        o_redirect_pc,
  output logic               o_stall_IF,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_mispredict_cnt
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} state_t;

  state_t             state;
  logic [INDEX_W-1:0] sweep_idx;
  logic               mis;
  logic               upd_alloc;
  logic               upd_inval;
  logic [INDEX_W-1:0] ex_idx;
  logic [TAG_W-1:0]   ex_tag;

  assign ex_idx = i_ex_pc[INDEX_W+1:2];
  assign ex_tag = i_ex_pc[31:32-TAG_W];

  assign mis = i_ex_valid & ((i_ex_btb_hit & ~i_ex_taken) |
                             (i_ex_btb_hit & i_ex_taken & ~i_ex_target_match) |
                             (~i_ex_btb_hit & i_ex_taken));

  assign upd_alloc = i_ex_valid & i_ex_taken & (~i_ex_btb_hit | ~i_ex_target_match);
  assign upd_inval = i_ex_valid & i_ex_btb_hit & ~i_ex_taken;

  // Redirect is held at its reset value while reset is asserted, otherwise it tracks EX directly.
  assign o_redirect    = i_rstn & mis;
  assign o_redirect_pc = !i_rstn ? 32'd0 :
                         (mis & i_ex_taken) ? i_ex_target : i_ex_pc_plus4;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state            <= S_INIT;
      sweep_idx        <= '0;
      o_btb_wren       <= 1'b0;
      o_btb_waddr      <= '0;
      o_btb_wtarget    <= '0;
      o_btb_wvt        <= '0;
      o_busy           <= 1'b1;
      o_stall_IF       <= 1'b1;
      o_mispredict_cnt <= '0;
    end else begin
      if (mis && (o_mispredict_cnt != {CNT_W{1'b1}}))
        o_mispredict_cnt <= o_mispredict_cnt + 1'b1;

      // Busy follows the state one cycle late so it covers exactly the sweep write cycles.
      o_busy     <= (state != S_RUN);
      o_stall_IF <= (state != S_RUN);

      case (state)
        S_INIT, S_FLUSH: begin
          o_btb_wren    <= 1'b1;
          o_btb_waddr   <= sweep_idx;
          o_btb_wtarget <= '0;
          o_btb_wvt     <= '0;
          sweep_idx     <= sweep_idx + 1'b1;
          if (sweep_idx == {INDEX_W{1'b1}})
            state <= S_RUN;
        end
        S_RUN: begin
          if (i_flush_req) begin
            state      <= S_FLUSH;
            o_btb_wren <= 1'b0;
          end else if (upd_alloc || upd_inval) begin
            o_btb_wren    <= 1'b1;
            o_btb_waddr   <= ex_idx;
            o_btb_wtarget <= i_ex_target;
            o_btb_wvt     <= {upd_alloc, ex_tag};
          end else begin
            o_btb_wren <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl: reset sweep, update/redirect cases, flush, mid-sweep reset, counter saturation.
module tb_btb_ctrl;

  logic        i_clk;
  logic        i_rstn;
  logic        i_flush_req;
  logic        i_ex_valid, i_ex_taken, i_ex_btb_hit, i_ex_target_match;
  logic [31:0] i_ex_pc, i_ex_target, i_ex_pc_plus4;
  logic        o_btb_wren;
  logic [9:0]  o_btb_waddr;
  logic [31:0] o_btb_wtarget;
  logic [20:0] o_btb_wvt;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_stall_IF, o_busy;
  logic [15:0] o_mispredict_cnt;

  int errors = 0;
  int checks = 0;
  int bad;
  logic [15:0] exp_cnt;

  btb_ctrl #(.INDEX_W(10), .TAG_W(20), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_flush_req(i_flush_req),
    .i_ex_valid(i_ex_valid), .i_ex_taken(i_ex_taken), .i_ex_btb_hit(i_ex_btb_hit),
    .i_ex_target_match(i_ex_target_match), .i_ex_pc(i_ex_pc), .i_ex_target(i_ex_target),
    .i_ex_pc_plus4(i_ex_pc_plus4), .o_btb_wren(o_btb_wren), .o_btb_waddr(o_btb_waddr),
    .o_btb_wtarget(o_btb_wtarget), .o_btb_wvt(o_btb_wvt), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_stall_IF(o_stall_IF), .o_busy(o_busy),
    .o_mispredict_cnt(o_mispredict_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic t, input logic h, input logic m,
                        input logic [31:0] pc, input logic [31:0] tgt);
    i_ex_valid = v; i_ex_taken = t; i_ex_btb_hit = h; i_ex_target_match = m;
    i_ex_pc = pc; i_ex_target = tgt; i_ex_pc_plus4 = pc + 32'd4;
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wren"}, o_btb_wren, 0);
    chk({tag, "_waddr"}, o_btb_waddr, 0);
    chk({tag, "_wtarget"}, o_btb_wtarget, 0);
    chk({tag, "_wvt"}, o_btb_wvt, 0);
    chk({tag, "_redirect"}, o_redirect, 0);
    chk({tag, "_redirect_pc"}, o_redirect_pc, 0);
    chk({tag, "_cnt"}, o_mispredict_cnt, 0);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_stall"}, o_stall_IF, 1);
  endtask

  // Runs n sweep cycles expecting addresses 0..n-1 with cleared data, returns mismatching cycles.
  task automatic run_sweep(input int n, input int flush_at, output int nbad);
    nbad = 0;
    for (int k = 0; k < n; k++) begin
      step();
      i_flush_req = (k == flush_at);
      if (!(o_btb_wren === 1'b1 && o_btb_waddr === 10'(k) && o_btb_wvt === 21'd0 &&
            o_btb_wtarget === 32'd0 && o_busy === 1'b1 && o_stall_IF === 1'b1))
        nbad++;
    end
    i_flush_req = 1'b0;
  endtask

  initial begin
    i_rstn = 1'b0; i_flush_req = 1'b0;
    set_ex(1, 1, 0, 0, 32'h0000_1008, 32'h0000_1234);
    exp_cnt = 16'd0;
    step(); step();
    chk_reset_vals("rst");
    set_ex(0, 0, 0, 0, 32'h0, 32'h0);
    i_rstn = 1'b1;

    // Initial sweep; a taken miss at sweep index 100 redirects and counts but never writes.
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      step();
      if (k == 100) begin
        set_ex(1, 1, 0, 0, 32'h0000_1008, 32'h0000_2000);
        #1;
        chk("sweep_redirect", o_redirect, 1);
        chk("sweep_redirect_pc", o_redirect_pc, 32'h2000);
        exp_cnt++;
      end else begin
        set_ex(0, 0, 0, 0, 32'h0, 32'h0);
      end
      if (!(o_btb_wren === 1'b1 && o_btb_waddr === 10'(k) && o_btb_wvt === 21'd0 &&
            o_btb_wtarget === 32'd0 && o_busy === 1'b1 && o_stall_IF === 1'b1))
        bad++;
    end
    chk("init_sweep", bad, 0);
    step();
    chk("run_busy", o_busy, 0);
    chk("run_stall", o_stall_IF, 0);
    chk("run_wren_idle", o_btb_wren, 0);
    chk("cnt_after_sweep", o_mispredict_cnt, exp_cnt);

    // Taken miss allocates at index 2, tag 1.
    set_ex(1, 1, 0, 0, 32'h0000_1008, 32'h0000_2000);
    #1;
    chk("alloc_redirect", o_redirect, 1);
    chk("alloc_redirect_pc", o_redirect_pc, 32'h2000);
    exp_cnt++;
    step();
    set_ex(0, 0, 0, 0, 32'h0, 32'h0);
    chk("alloc_wren", o_btb_wren, 1);
    chk("alloc_waddr", o_btb_waddr, 2);
    chk("alloc_wtarget", o_btb_wtarget, 32'h2000);
    chk("alloc_wvt", o_btb_wvt, 21'h10_0001);
    chk("alloc_cnt", o_mispredict_cnt, exp_cnt);

    // Correct taken prediction: no redirect, no write.
    set_ex(1, 1, 1, 1, 32'h0000_1008, 32'h0000_2000);
    #1;
    chk("hit_redirect", o_redirect, 0);
    chk("hit_redirect_pc", o_redirect_pc, 32'h100C);
    step();
    chk("hit_wren", o_btb_wren, 0);
    chk("hit_cnt", o_mispredict_cnt, exp_cnt);

    // Hit but not taken: redirect to fall-through and invalidate the entry.
    set_ex(1, 0, 1, 0, 32'h0000_1008, 32'h0000_2000);
    #1;
    chk("inval_redirect", o_redirect, 1);
    chk("inval_redirect_pc", o_redirect_pc, 32'h100C);
    exp_cnt++;
    step();
    set_ex(0, 0, 0, 0, 32'h0, 32'h0);
    chk("inval_wren", o_btb_wren, 1);
    chk("inval_waddr", o_btb_waddr, 2);
    chk("inval_wvt", o_btb_wvt, 21'h00_0001);
    chk("inval_wtarget", o_btb_wtarget, 32'h2000);

    // Back-to-back updates: taken miss then target mismatch, then a not-taken miss.
    set_ex(1, 1, 0, 0, 32'h0000_3004, 32'h0000_0040);
    exp_cnt++;
    step();
    chk("b2b0_wren", o_btb_wren, 1);
    chk("b2b0_waddr", o_btb_waddr, 1);
    chk("b2b0_wvt", o_btb_wvt, 21'h10_0003);
    set_ex(1, 1, 1, 0, 32'hABCD_E010, 32'h0000_0080);
    #1;
    chk("b2b1_redirect_pc", o_redirect_pc, 32'h80);
    exp_cnt++;
    step();
    chk("b2b1_wren", o_btb_wren, 1);
    chk("b2b1_waddr", o_btb_waddr, 4);
    chk("b2b1_wtarget", o_btb_wtarget, 32'h80);
    chk("b2b1_wvt", o_btb_wvt, 21'h1A_BCDE);
    set_ex(1, 0, 0, 0, 32'h0000_5000, 32'h0000_9999);
    #1;
    chk("ntmiss_redirect", o_redirect, 0);
    chk("ntmiss_redirect_pc", o_redirect_pc, 32'h5004);
    step();
    chk("ntmiss_wren", o_btb_wren, 0);
    chk("b2b_cnt", o_mispredict_cnt, exp_cnt);

    // Flush with a taken miss in the same cycle: redirect yes, write no, full sweep follows.
    set_ex(1, 1, 0, 0, 32'h0000_1008, 32'h0000_2000);
    i_flush_req = 1'b1;
    #1;
    chk("flush_redirect", o_redirect, 1);
    exp_cnt++;
    step();
    i_flush_req = 1'b0;
    set_ex(0, 0, 0, 0, 32'h0, 32'h0);
    chk("flush_no_write", o_btb_wren, 0);
    run_sweep(1024, 500, bad);
    chk("flush_sweep", bad, 0);
    step();
    chk("flush_done_busy", o_busy, 0);
    chk("flush_done_wren", o_btb_wren, 0);
    chk("flush_cnt", o_mispredict_cnt, exp_cnt);

    // Reset at sweep index 300, then the sweep restarts from 0.
    i_flush_req = 1'b1;
    step();
    i_flush_req = 1'b0;
    run_sweep(301, -1, bad);
    chk("pre_reset_sweep", bad, 0);
    i_rstn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    i_rstn = 1'b1;
    run_sweep(1024, -1, bad);
    chk("restart_sweep", bad, 0);
    step();
    chk("restart_busy", o_busy, 0);

    // Counter saturation with continuous mispredicts.
    set_ex(1, 1, 0, 0, 32'h0000_1008, 32'h0000_2000);
    repeat (65534) @(posedge i_clk);
    #1;
    chk("cnt_fffe", o_mispredict_cnt, 16'hFFFE);
    repeat (4) @(posedge i_clk);
    #1;
    chk("cnt_sat", o_mispredict_cnt, 16'hFFFF);
    set_ex(0, 0, 0, 0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_ctrl.md
Name: btb_ctrl

Overview:
- Sequencing controller for the branch target buffer (BTB) target RAM and valid-tag RAM.
- After reset, and on request, it sweeps every BTB entry to clear its valid bit, because the RAMs have no reset. It stalls fetch while the sweep runs.
- During normal running it decides, from the EX-stage branch resolution, whether and how to write the BTB. It also generates the fetch redirect.
- Sits between the EX stage, the BTB write port and the IF next-PC mux.

Parameters:
- INDEX_W, 10, BTB index width; the BTB has 2^INDEX_W entries and is indexed by pc[INDEX_W+1:2].
- TAG_W, 20, tag width; the tag is pc[31:32-TAG_W]. INDEX_W+TAG_W+2 must equal 32.
- CNT_W, 16, width of the misprediction performance counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_flush_req  in  1  single-cycle request to invalidate the whole BTB (fence or context switch).
- i_ex_valid  in  1  EX holds a resolved instruction this cycle.
- i_ex_taken  in  1  EX resolved taken branch or jump (pc_sel).
- i_ex_btb_hit  in  1  this instruction hit in the BTB at IF.
- i_ex_target_match  in  1  the predicted target equals the resolved target.
- i_ex_pc  in  32  PC of the EX instruction.
- i_ex_target  in  32  resolved target.
- i_ex_pc_plus4  in  32  EX PC + 4.
- o_btb_wren  out  1  BTB write enable, driving both RAMs.
- o_btb_waddr  out  INDEX_W  write index.
- o_btb_wtarget  out  32  target write data.
- o_btb_wvt  out  TAG_W+1  {valid, tag} write data.
- o_redirect  out  1  mispredict: flush IF/ID and load o_redirect_pc.
- o_redirect_pc  out  32  corrected next PC.
- o_stall_IF  out  1  hold the PC and fetch.
- o_busy  out  1  a sweep is in progress.
- o_mispredict_cnt  out  CNT_W  saturating misprediction count.

Behaviour:
- State machine has three states: S_INIT, S_RUN, S_FLUSH.
  - Async reset forces S_INIT and sweep index 0, including when reset arrives mid-sweep.
- Reset values: o_btb_wren=0, o_btb_waddr=0, o_btb_wtarget=0, o_btb_wvt=0, o_redirect=0, o_redirect_pc=0, o_mispredict_cnt=0, o_busy=1, o_stall_IF=1.
- Sweep (S_INIT and S_FLUSH):
  - Each cycle: o_btb_wren=1, o_btb_waddr=index, o_btb_wvt=0, o_btb_wtarget=0; then index increments.
  - After writing index 2^INDEX_W-1 the controller moves to S_RUN next cycle, with the index wrapped to 0. The sweep takes exactly 2^INDEX_W write cycles.
  - o_busy=o_stall_IF=1 throughout the sweep.
  - EX updates arriving during a sweep are dropped; they are never written afterwards.
  - i_flush_req during a sweep is ignored; the sweep is not restarted.
- S_RUN:
  - i_flush_req moves to S_FLUSH next cycle. A BTB update computed in the same cycle is dropped; flush wins.
- Misprediction (combinational, all states):
  - mis = i_ex_valid & ((hit & ~taken) | (hit & taken & ~match) | (~hit & taken)).
  - o_redirect = mis.
  - o_redirect_pc = taken ? i_ex_target : i_ex_pc_plus4; when mis=0 it holds i_ex_pc_plus4.
  - Redirect is never suppressed by a sweep.
- BTB update (S_RUN only; registered, so the write occurs one cycle after EX):
  - Allocate/fix: i_ex_valid & taken & (~hit | ~match) writes waddr=pc[INDEX_W+1:2], wtarget=i_ex_target, wvt={1, pc tag}.
  - Invalidate: i_ex_valid & hit & ~taken writes wvt={0, pc tag}, wtarget=i_ex_target.
  - Correct prediction (hit & taken & match), or not-taken miss: no write.
  - o_btb_wren is high for exactly one cycle per update. Back-to-back EX updates produce back-to-back writes, with no stall.
- Counter:
  - Increments by 1 on each cycle with mis=1, in any state.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.

Test Plan:
- Release reset -> o_busy=1 for exactly 1024 cycles; waddr steps 0..1023 with wvt=0; o_busy and o_stall_IF drop on cycle 1025 and the controller is in S_RUN.
- S_RUN, ex_pc=0x0000_1008, taken=1, hit=0, target=0x0000_2000 -> o_redirect=1 and redirect_pc=0x2000 the same cycle; next cycle wren=1, waddr=2, wtarget=0x2000, wvt={1,20'h00001}; cnt=1.
- S_RUN, hit=1, taken=1, match=1 -> o_redirect=0, no write, cnt unchanged. Then hit=1, taken=0, pc_plus4=0x100C -> redirect_pc=0x100C; next cycle writes wvt valid=0 at waddr=2.
- i_flush_req in the same cycle as a taken miss -> redirect still asserted; no update write; the 1024-cycle sweep follows. A second flush_req at sweep index 500 -> the sweep still ends after 1024 cycles total.
- Reset asserted at sweep index 300 -> all outputs take their reset values immediately; after release the sweep restarts at index 0.
- Force 65536+2 mispredicts (CNT_W=16) -> o_mispredict_cnt stays at 0xFFFF.
